// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - instruction-field input stream and memory-write output stream bundle
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    // Instruction fields from the loader
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [31:0]       imm;

    // Instruction-memory write port
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_data;

    // Loader / memory side
    modport master (
        output in_valid, in_last, opcode, rd, rs1, rs2, funct3, imm, out_ready,
        input  in_ready, out_valid, out_addr, out_data
    );

    // Encoder side
    modport slave (
        input  in_valid, in_last, opcode, rd, rs1, rs2, funct3, imm, out_ready,
        output in_ready, out_valid, out_addr, out_data
    );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs RV32I OP-IMM/BRANCH fields into words and streams them to instruction memory (optional INSTR_ENC_RANGE_CHECK_EN)
module instr_encoder #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   o_count,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [6:0]        OP_IMM    = 7'b0010011;
    localparam logic [6:0]        OP_BRANCH = 7'b1100011;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [31:0]       r_out_data;
    logic              r_last_pend;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_err;

    logic              w_in_ready;
    logic              w_in_hs;
    logic              w_out_hs;
    logic              w_is_i;
    logic              w_is_b;
    logic              w_range_bad;
    logic              w_bad;
    logic              w_good;
    logic [31:0]       w_enc_i;
    logic [31:0]       w_enc_b;

    // Once the final word is registered, no more fields are taken until it drains.
    assign w_in_ready = (r_state == S_RUN) && !i_start && !r_last_pend
                        && (!r_out_valid || bus.out_ready);
    assign w_in_hs    = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && bus.out_ready;

    assign w_is_i = (bus.opcode == OP_IMM);
    assign w_is_b = (bus.opcode == OP_BRANCH);

`ifdef INSTR_ENC_RANGE_CHECK_EN
    // In range means every bit above the encodable field is a copy of the field's sign bit.
    assign w_range_bad = (w_is_i && !((&bus.imm[31:11]) || !(|bus.imm[31:11])))
                      || (w_is_b && (!((&bus.imm[31:12]) || !(|bus.imm[31:12])) || bus.imm[0]));
`else
    // Without the check, high immediate bits are simply truncated.
    logic w_unused_imm;
    assign w_unused_imm = &{1'b0, bus.imm[31:13]};
    assign w_range_bad  = 1'b0;
`endif

    assign w_bad  = w_in_hs && (!(w_is_i || w_is_b) || w_range_bad);
    assign w_good = w_in_hs && !w_bad;

    assign w_enc_i = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
    assign w_enc_b = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                      bus.imm[4:1], bus.imm[11], bus.opcode};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: start always restarts; errors trap until the next start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (w_bad)                         w_state_nxt = S_ERR;
                else if (r_last_pend && w_out_hs)  w_state_nxt = S_IDLE;
            end
            default: ;
        endcase
        if (i_start) w_state_nxt = S_RUN;
    end

    // Output register: load a good word, empty on the memory handshake, drop on start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_last_pend <= 1'b0;
        end else if (i_start) begin
            r_out_valid <= 1'b0;
            r_last_pend <= 1'b0;
        end else if (w_good) begin
            r_out_valid <= 1'b1;
            r_out_addr  <= r_addr;
            r_out_data  <= w_is_b ? w_enc_b : w_enc_i;
            r_last_pend <= bus.in_last;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_last_pend <= 1'b0;
        end
    end

    // Word address counter; wraps naturally at the counter width.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_addr <= '0;
        else if (i_start) r_addr <= i_base_addr;
        else if (w_good)  r_addr <= r_addr + ADDR_ONE;
    end

    // Words written since start, plus the end-of-program pulse and sticky error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else if (i_start) begin
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_out_hs) r_count <= r_count + CNT_ONE;
            r_done <= r_last_pend && w_out_hs;
            if (w_bad) r_err <= 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign o_count       = r_count;
    assign o_done        = r_done;
    assign o_err         = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed bench for instr_encoder with a transaction-level reference model
module tb_instr_encoder;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              err;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_base_addr (base_addr),
        .bus         (bus.slave),
        .o_count     (count),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] encode(input logic [6:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3, input logic [31:0] imm);
        logic [31:0] w;
        w = 32'(op) | (32'(rs1) << 15) | (32'(f3) << 12);
        if (op == 7'h13)
            w = w | ((imm & 32'hFFF) << 20) | (32'(rd) << 7);
        else
            w = w | (32'(rs2) << 20) | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
        return w;
    endfunction

    function automatic bit legal(input logic [6:0] op, input logic [31:0] imm);
        bit ok;
        ok = (op == 7'h13) || (op == 7'h63);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        begin
            int s;
            s = $signed(imm);
            if (op == 7'h13 && (s < -2048 || s > 2047)) ok = 1'b0;
            if (op == 7'h63 && (s < -4096 || s > 4094 || (s % 2) != 0)) ok = 1'b0;
        end
`endif
        return ok;
    endfunction

    bit              m_run, m_err, m_done;
    int              m_addr, m_count;
    logic [ADDR_W-1:0] q_addr[$];
    logic [31:0]     q_data[$];
    bit              q_last[$];
    bit              m_ohs, m_ihs, m_dn;

    function automatic bit exp_in_ready();
        return m_run && !start && !(q_data.size() > 0 && q_last[0])
               && (q_data.size() == 0 || bus.out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_err = 0; m_done = 0; m_addr = 0; m_count = 0;
            q_addr.delete(); q_data.delete(); q_last.delete();
        end else begin
            m_ohs = (q_data.size() > 0) && bus.out_ready;
            m_ihs = bus.in_valid && exp_in_ready();
            if (start) begin
                m_run = 1; m_err = 0; m_done = 0; m_addr = int'(base_addr); m_count = 0;
                q_addr.delete(); q_data.delete(); q_last.delete();
            end else begin
                m_dn = m_ohs && q_last[0];
                if (m_ohs) begin
                    void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_last.pop_front());
                    m_count++;
                end
                if (m_ihs) begin
                    if (legal(bus.opcode, bus.imm)) begin
                        q_addr.push_back(ADDR_W'(m_addr));
                        q_data.push_back(encode(bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3, bus.imm));
                        q_last.push_back(bus.in_last);
                        m_addr = (m_addr + 1) % (1 << ADDR_W);
                    end else begin
                        m_err = 1; m_run = 0;
                    end
                end
                if (m_dn) m_run = 0;
                m_done = m_dn;
            end
        end
    end

    // ---------------- compare + write log ----------------
    int              cyc_n = 0;
    int              n_done = 0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [31:0]     log_data[$];
    int              log_cyc[$];

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", bus.in_ready, exp_in_ready());
            chk("out_valid", bus.out_valid, q_data.size() > 0);
            if (q_data.size() > 0) begin
                chk("out_addr", bus.out_addr, q_addr[0]);
                chk("out_data", bus.out_data, q_data[0]);
            end
            chk("count", count, m_count);
            chk("done", done, m_done);
            chk("err", err, m_err);
            if (bus.out_valid && bus.out_ready) begin
                log_addr.push_back(bus.out_addr);
                log_data.push_back(bus.out_data);
                log_cyc.push_back(cyc_n);
            end
            if (done) n_done++;
        end
    end

    // ---------------- stimulus helpers ----------------
    int or_mode = 0;  // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        start = 1'b1; base_addr = b;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                        input bit last, input int bound, output bit acc);
        bus.in_valid = 1'b1; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.imm = imm; bus.in_last = last;
        acc = 0;
        for (int i = 0; i < bound && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1;
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_imm(input bit is_b);
        logic [31:0] v;
        int edges[10] = '{-4097, -4096, -4095, -2049, -2048, 2047, 2048, 4094, 4095, 4096};
        case ($urandom_range(0, 4))
            0:       v = 32'($urandom_range(0, 127)) - 32'd64;
            1:       v = 32'(edges[$urandom_range(0, 9)]);
            2:       v = $urandom;
            default: v = 32'($urandom_range(0, 4095)) - 32'd2048;
        endcase
        if (is_b && $urandom_range(0, 3) != 0) v[0] = 1'b0;
        return v;
    endfunction

    // ---------------- test sequence ----------------
    bit acc, ok;
    int n0, nd0;

    initial begin
        bus.in_valid = 0; bus.in_last = 0; bus.opcode = 0; bus.rd = 0; bus.rs1 = 0;
        bus.rs2 = 0; bus.funct3 = 0; bus.imm = 0; bus.out_ready = 1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst in_ready", bus.in_ready, 0);
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst out_addr", bus.out_addr, 0);
        chk("rst out_data", bus.out_data, 0);
        chk("rst count", count, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        @(posedge clk); #3; rst_n = 1'b1;
        cyc(1);

        // Single addi with last
        n0 = log_data.size();
        do_start(10'h010);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b1, 20, acc);
        chk("t1 accept", acc, 1);
        wait_done(20, ok);
        chk("t1 done", ok, 1);
        chk("t1 data", log_data[n0], 32'h00500093);
        chk("t1 addr", log_addr[n0], 10'h010);
        chk("t1 count", count, 1);

        // Three words back to back
        n0 = log_data.size();
        do_start(10'h020);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFF, 1'b0, 20, acc);
        send(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8, 1'b0, 20, acc);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC, 1'b1, 20, acc);
        wait_done(20, ok);
        chk("t2 done", ok, 1);
        chk("t2 d0", log_data[n0], 32'hFFF00093);
        chk("t2 d1", log_data[n0+1], 32'h00208463);
        chk("t2 d2", log_data[n0+2], 32'hFE000EE3);
        chk("t2 a2", log_addr[n0+2], 10'h022);
        chk("t2 rate", log_cyc[n0+2] - log_cyc[n0], 2);

        // Backpressure for four cycles
        n0 = log_data.size();
        or_mode = 2;
        do_start(10'h040);
        send(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 32'd7, 1'b0, 20, acc);
        bus.in_valid = 1'b1; bus.rd = 5'd3; bus.imm = 32'd9; bus.in_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall data", bus.out_data, 32'h00700113);
            chk("stall addr", bus.out_addr, 10'h040);
            chk("stall in_ready", bus.in_ready, 0);
            @(posedge clk); #1;
        end
        or_mode = 0;
        send(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 32'd9, 1'b1, 20, acc);
        wait_done(20, ok);
        chk("stall words", log_data.size() - n0, 2);
        chk("stall w1", log_data[n0+1], 32'h00900193);
        chk("stall a1", log_addr[n0+1], 10'h041);

        // Address wrap
        n0 = log_data.size();
        do_start(10'h3FF);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 1'b0, 20, acc);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2, 1'b1, 20, acc);
        wait_done(20, ok);
        chk("wrap a0", log_addr[n0], 10'h3FF);
        chk("wrap a1", log_addr[n0+1], 10'h000);

        // Out-of-range immediates
        n0 = log_data.size();
        do_start(10'h050);
        send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 1'b1, 20, acc);
`ifdef INSTR_ENC_RANGE_CHECK_EN
        nd0 = n_done;
        @(negedge clk);
        chk("rng err", err, 1);
        chk("rng in_ready", bus.in_ready, 0);
        cyc(3);
        chk("rng nowrite", log_data.size(), n0);
        chk("rng nodone", n_done, nd0);
        do_start(10'h050);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 1'b1, 20, acc);
        cyc(3);
        chk("odd err", err, 1);
        chk("odd nowrite", log_data.size(), n0);
        chk("odd nodone", n_done, nd0);
`else
        wait_done(20, ok);
        chk("trunc data", log_data[n0], 32'h80000093);
        chk("trunc err", err, 0);
        do_start(10'h050);
        send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 1'b1, 20, acc);
        wait_done(20, ok);
        chk("odd data", log_data[n0+1], 32'h00000163);
        chk("odd err", err, 0);
`endif

        // Unsupported opcode
        n0 = log_data.size();
        do_start(10'h060);
        send(7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0, 1'b1, 20, acc);
        cyc(2);
        chk("badop err", err, 1);
        chk("badop nowrite", log_data.size(), n0);

        // Start while stalled drops the pending word
        or_mode = 2;
        do_start(10'h100);
        send(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 32'd1, 1'b0, 20, acc);
        n0 = log_data.size();
        cyc(1);
        do_start(10'h200);
        @(negedge clk);
        chk("restart out_valid", bus.out_valid, 0);
        chk("restart count", count, 0);
        @(posedge clk); #1;
        or_mode = 0;
        send(7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 32'd2, 1'b1, 20, acc);
        wait_done(20, ok);
        chk("restart words", log_data.size() - n0, 1);
        chk("restart addr", log_addr[n0], 10'h200);
        chk("restart data", log_data[n0], 32'h00200313);

        // Randomized programs
        or_mode = 1;
        for (int p = 0; p < 30; p++) begin
            int nw;
            do_start(ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1)));
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw && !m_err; w++) begin
                int k;
                logic [6:0] op;
                k = $urandom_range(0, 19);
                op = (k < 9) ? 7'h13 : (k < 18) ? 7'h63 : 7'h33;
                cyc($urandom_range(0, 2));
                send(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                     rand_imm(op == 7'h63), (w == nw - 1), 100, acc);
                chk("rnd accept", acc, 1);
            end
            if (!m_err) begin
                wait_done(200, ok);
                chk("rnd done", ok, 1);
            end else begin
                cyc(4);
            end
        end

        // Asynchronous reset mid-program
        or_mode = 2;
        do_start(10'h0AA);
        send(7'h13, 5'd7, 5'd1, 5'd0, 3'd0, 32'd33, 1'b0, 20, acc);
        #3; rst_n = 1'b0; #1;
        chk("arst in_ready", bus.in_ready, 0);
        chk("arst out_valid", bus.out_valid, 0);
        chk("arst out_addr", bus.out_addr, 0);
        chk("arst out_data", bus.out_data, 0);
        chk("arst count", count, 0);
        chk("arst done", done, 0);
        chk("arst err", err, 0);
        @(posedge clk); #3; rst_n = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
